// File: rtl/low_contrast_test_if.sv
// Sample/result bundle for the low-contrast rejection stage of a keypoint
// detector. The upstream stage drives the sample side; the checker drives
// the result side.
interface low_contrast_test_if #(
    parameter int DW   = 9,
    parameter int DETW = 17,
    parameter int TW   = 8,
    parameter int OW   = 48
);
    logic                   ivalid;
    logic signed [DW-1:0]   ipixel_data;
    logic signed [DW-1:0]   iadj11, iadj12, iadj13;
    logic signed [DW-1:0]   iadj21, iadj22, iadj23;
    logic signed [DW-1:0]   iadj31, iadj32, iadj33;
    logic signed [DETW-1:0] idet;
    logic signed [DW-1:0]   idx, idy, ids;
    logic [TW-1:0]          ithreshold;
    logic                   ovalid;
    logic signed [OW-1:0]   oleft_value;
    logic signed [OW-1:0]   oright_value;
    logic                   okeep;
    logic                   odet_zero;

    modport master (
        output ivalid, ipixel_data,
        output iadj11, iadj12, iadj13, iadj21, iadj22, iadj23, iadj31, iadj32, iadj33,
        output idet, idx, idy, ids, ithreshold,
        input  ovalid, oleft_value, oright_value, okeep, odet_zero
    );

    modport slave (
        input  ivalid, ipixel_data,
        input  iadj11, iadj12, iadj13, iadj21, iadj22, iadj23, iadj31, iadj32, iadj33,
        input  idet, idx, idy, ids, ithreshold,
        output ovalid, oleft_value, oright_value, okeep, odet_zero
    );
endinterface

// File: rtl/low_contrast_test.sv
// Low-contrast keypoint test. With e = 2*p*det - g'*adj*g, a candidate is kept
// when e^2 >= T^2 * 4*det^2, i.e. |p - q/(2*det)| >= T, without any division.
// Seven-stage fully pipelined datapath, exact arithmetic throughout; only the
// reported values are clamped, the keep decision uses the exact products.
module low_contrast_test #(
    parameter int DW   = 9,
    parameter int DETW = 17,
    parameter int TW   = 8,
    parameter int OW   = 48
) (
    input logic                iclk,
    input logic                irst_n,
    low_contrast_test_if.slave bus
);
    localparam int PW   = 2 * DW;                          // adj*g product
    localparam int VW   = PW + 2;                          // row sum of three products
    localparam int GW   = DW + VW;                         // g_i * v_i
    localparam int QW   = GW + 2;                          // q = sum of three
    localparam int PDW  = DW + DETW;                       // p*det
    localparam int PD2W = PDW + 1;                         // 2*p*det
    localparam int EW   = ((PD2W > QW) ? PD2W : QW) + 1;   // e
    localparam int E2W  = 2 * EW;                          // e^2
    localparam int D2W  = 2 * DETW;                        // det^2
    localparam int D4W  = D2W + 2;                         // 4*det^2
    localparam int T2W  = 2 * TW;                          // T^2 (unsigned)
    localparam int TTW  = T2W + D4W;                       // T^2*4*det^2 (unsigned)
    localparam int CW0  = (E2W > TTW) ? E2W : TTW;
    localparam int CW   = (CW0 > OW) ? CW0 : OW;           // common compare width

    // Clamp a non-negative exact value to the largest positive OW-bit number.
    function automatic logic signed [OW-1:0] sat_ow(input logic [CW-1:0] v);
        logic [CW-1:0] lim;
        lim = CW'({1'b0, {(OW-1){1'b1}}});
        if (v > lim) begin
            sat_ow = {1'b0, {(OW-1){1'b1}}};
        end else begin
            sat_ow = OW'(v);
        end
    endfunction

    logic signed [DW-1:0]   adj_s [9];
    logic signed [DW-1:0]   g_s   [3];

    assign adj_s[0] = bus.iadj11;
    assign adj_s[1] = bus.iadj12;
    assign adj_s[2] = bus.iadj13;
    assign adj_s[3] = bus.iadj21;
    assign adj_s[4] = bus.iadj22;
    assign adj_s[5] = bus.iadj23;
    assign adj_s[6] = bus.iadj31;
    assign adj_s[7] = bus.iadj32;
    assign adj_s[8] = bus.iadj33;
    assign g_s[0]   = bus.idx;
    assign g_s[1]   = bus.idy;
    assign g_s[2]   = bus.ids;

    logic [6:1]             vld_q;
    logic signed [DW-1:0]   p_q   [1:2];
    logic signed [DW-1:0]   g_q   [1:2][0:2];
    logic signed [DETW-1:0] det_q [1:4];
    logic [TW-1:0]          t_q   [1:4];
    logic signed [PW-1:0]   s1_prod_q [9];
    logic signed [VW-1:0]   s2_v_q  [3];
    logic signed [GW-1:0]   s3_gv_q [3];
    logic signed [PDW-1:0]  s3_pd_q;
    logic signed [QW-1:0]   s4_q_q;
    logic signed [PD2W-1:0] s4_pd2_q;
    logic signed [EW-1:0]   s5_e_q;
    logic signed [D2W-1:0]  s5_d2_q;
    logic [T2W-1:0]         s5_t2_q;
    logic signed [E2W-1:0]  s6_e2_q;
    logic signed [D4W-1:0]  s6_d4_q;
    logic [TTW-1:0]         s6_tt_q;
    logic                   ovalid_q;
    logic                   okeep_q;
    logic                   odet_zero_q;
    logic signed [OW-1:0]   oleft_q;
    logic signed [OW-1:0]   oright_q;

    // Valid shift register: the only control state; bubbles travel with it.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            vld_q <= 6'd0;
        end else begin
            vld_q <= {vld_q[5:1], bus.ivalid};
        end
    end

    // Side data (p, g, det, T) carried alongside the arithmetic until consumed.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int s = 1; s <= 2; s++) begin
                p_q[s] <= {DW{1'b0}};
                for (int j = 0; j < 3; j++) g_q[s][j] <= {DW{1'b0}};
            end
            for (int s = 1; s <= 4; s++) begin
                det_q[s] <= {DETW{1'b0}};
                t_q[s]   <= {TW{1'b0}};
            end
        end else begin
            p_q[1]   <= bus.ipixel_data;
            p_q[2]   <= p_q[1];
            det_q[1] <= bus.idet;
            t_q[1]   <= bus.ithreshold;
            for (int s = 2; s <= 4; s++) begin
                det_q[s] <= det_q[s-1];
                t_q[s]   <= t_q[s-1];
            end
            for (int j = 0; j < 3; j++) begin
                g_q[1][j] <= g_s[j];
                g_q[2][j] <= g_q[1][j];
            end
        end
    end

    // S1/S2: adj*g element products, then the three row sums v = adj*g.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int k = 0; k < 9; k++) s1_prod_q[k] <= {PW{1'b0}};
            for (int i = 0; i < 3; i++) s2_v_q[i] <= {VW{1'b0}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    s1_prod_q[3*i+j] <= PW'(adj_s[3*i+j]) * PW'(g_s[j]);
                end
                s2_v_q[i] <= VW'(s1_prod_q[3*i]) + VW'(s1_prod_q[3*i+1]) + VW'(s1_prod_q[3*i+2]);
            end
        end
    end

    // S3/S4: g_i*v_i and p*det, then q and 2*p*det.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int i = 0; i < 3; i++) s3_gv_q[i] <= {GW{1'b0}};
            s3_pd_q  <= {PDW{1'b0}};
            s4_q_q   <= {QW{1'b0}};
            s4_pd2_q <= {PD2W{1'b0}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                s3_gv_q[i] <= GW'(g_q[2][i]) * GW'(s2_v_q[i]);
            end
            s3_pd_q  <= PDW'(p_q[2]) * PDW'(det_q[2]);
            s4_q_q   <= QW'(s3_gv_q[0]) + QW'(s3_gv_q[1]) + QW'(s3_gv_q[2]);
            s4_pd2_q <= PD2W'(s3_pd_q) + PD2W'(s3_pd_q);
        end
    end

    // S5/S6: e, det^2, T^2, then e^2, 4*det^2 and the threshold product.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s5_e_q  <= {EW{1'b0}};
            s5_d2_q <= {D2W{1'b0}};
            s5_t2_q <= {T2W{1'b0}};
            s6_e2_q <= {E2W{1'b0}};
            s6_d4_q <= {D4W{1'b0}};
            s6_tt_q <= {TTW{1'b0}};
        end else begin
            s5_e_q  <= EW'(s4_pd2_q) - EW'(s4_q_q);
            s5_d2_q <= D2W'(det_q[4]) * D2W'(det_q[4]);
            s5_t2_q <= T2W'(t_q[4]) * T2W'(t_q[4]);
            s6_e2_q <= E2W'(s5_e_q) * E2W'(s5_e_q);
            s6_d4_q <= D4W'(s5_d2_q) <<< 2'd2;
            s6_tt_q <= (TTW'(s5_t2_q) * TTW'($unsigned(s5_d2_q))) << 2'd2;
        end
    end

    // S7: result registers load only with a valid result and hold otherwise.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ovalid_q    <= 1'b0;
            okeep_q     <= 1'b0;
            odet_zero_q <= 1'b0;
            oleft_q     <= {OW{1'b0}};
            oright_q    <= {OW{1'b0}};
        end else begin
            ovalid_q <= vld_q[6];
            if (vld_q[6]) begin
                oleft_q     <= sat_ow(CW'($unsigned(s6_e2_q)));
                oright_q    <= sat_ow(CW'($unsigned(s6_d4_q)));
                okeep_q     <= (s6_d4_q != {D4W{1'b0}}) &&
                               (CW'($unsigned(s6_e2_q)) >= CW'(s6_tt_q));
                odet_zero_q <= (s6_d4_q == {D4W{1'b0}});
            end
        end
    end

    assign bus.ovalid       = ovalid_q;
    assign bus.okeep        = okeep_q;
    assign bus.odet_zero    = odet_zero_q;
    assign bus.oleft_value  = oleft_q;
    assign bus.oright_value = oright_q;
endmodule

// File: tb/tb_low_contrast_test.sv
// Randomised scoreboard bench for low_contrast_test. Two instances (OW=48 and
// OW=16) receive identical samples; a reference model computes the exact
// e^2, 4*det^2 and keep decision, and a negedge monitor checks each instance.
module tb_low_contrast_test;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    low_contrast_test_if #(.OW(48)) ifa();
    low_contrast_test_if #(.OW(16)) ifb();

    low_contrast_test #(.OW(48)) dut_a (.iclk(clk), .irst_n(rst_n), .bus(ifa));
    low_contrast_test #(.OW(16)) dut_b (.iclk(clk), .irst_n(rst_n), .bus(ifb));

    assign ifb.ivalid      = ifa.ivalid;
    assign ifb.ipixel_data = ifa.ipixel_data;
    assign ifb.iadj11      = ifa.iadj11;
    assign ifb.iadj12      = ifa.iadj12;
    assign ifb.iadj13      = ifa.iadj13;
    assign ifb.iadj21      = ifa.iadj21;
    assign ifb.iadj22      = ifa.iadj22;
    assign ifb.iadj23      = ifa.iadj23;
    assign ifb.iadj31      = ifa.iadj31;
    assign ifb.iadj32      = ifa.iadj32;
    assign ifb.iadj33      = ifa.iadj33;
    assign ifb.idet        = ifa.idet;
    assign ifb.idx         = ifa.idx;
    assign ifb.idy         = ifa.idy;
    assign ifb.ids         = ifa.ids;
    assign ifb.ithreshold  = ifa.ithreshold;

    typedef struct {
        longint e2;
        longint d4;
        bit     keep;
        bit     dz;
        int     due;
    } exp_t;

    exp_t   qs [2][$];
    longint ll [2];
    longint lr [2];
    bit     lk [2];
    bit     lz [2];
    int     cyc    = 0;
    int     errors = 0;
    int     checks = 0;
    int     id [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int     gx [3] = '{1, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint sat(input longint v, input int ow);
        longint lim;
        lim = (longint'(1) << (ow - 1)) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: exact e = 2*p*det - g'*adj*g, pushed to both scoreboards.
    task automatic send(input bit v, input int p, input int det, input int a[9],
                        input int g[3], input int t);
        exp_t   x;
        longint vr, q, e;
        @(negedge clk);
        ifa.ivalid      = v;
        ifa.ipixel_data = 9'(p);
        ifa.iadj11 = 9'(a[0]); ifa.iadj12 = 9'(a[1]); ifa.iadj13 = 9'(a[2]);
        ifa.iadj21 = 9'(a[3]); ifa.iadj22 = 9'(a[4]); ifa.iadj23 = 9'(a[5]);
        ifa.iadj31 = 9'(a[6]); ifa.iadj32 = 9'(a[7]); ifa.iadj33 = 9'(a[8]);
        ifa.idet       = 17'(det);
        ifa.idx        = 9'(g[0]);
        ifa.idy        = 9'(g[1]);
        ifa.ids        = 9'(g[2]);
        ifa.ithreshold = 8'(t);
        if (v) begin
            q = 0;
            for (int i = 0; i < 3; i++) begin
                vr = 0;
                for (int j = 0; j < 3; j++) vr += longint'(a[3*i+j]) * longint'(g[j]);
                q += longint'(g[i]) * vr;
            end
            e      = 2 * longint'(p) * longint'(det) - q;
            x.e2   = e * e;
            x.d4   = 4 * longint'(det) * longint'(det);
            x.dz   = (det == 0);
            x.keep = !x.dz && (x.e2 >= longint'(t) * longint'(t) * x.d4);
            x.due  = cyc + 7;
            qs[0].push_back(x);
            qs[1].push_back(x);
        end
    endtask

    task automatic send_rand(input bit v);
        int ra [9];
        int rg [3];
        int p, det, t;
        for (int k = 0; k < 9; k++) ra[k] = int'($urandom_range(0, 511)) - 256;
        for (int k = 0; k < 3; k++) rg[k] = int'($urandom_range(0, 511)) - 256;
        p   = int'($urandom_range(0, 511)) - 256;
        det = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 131071)) - 65536;
        t   = int'($urandom_range(0, 255));
        send(v, p, det, ra, rg, t);
    endtask

    task automatic mon(input int d, input bit ov, input longint ol, input longint orr,
                       input bit k, input bit z);
        exp_t x;
        bit   expv;
        int   ow;
        ow = (d == 0) ? 48 : 16;
        while (qs[d].size() > 0 && qs[d][0].due < cyc) void'(qs[d].pop_front());
        expv = (qs[d].size() > 0) && (qs[d][0].due == cyc);
        chk($sformatf("ovalid[%0d]", d), longint'(ov), longint'(expv));
        if (ov && expv) begin
            x = qs[d].pop_front();
            ll[d] = sat(x.e2, ow);
            lr[d] = sat(x.d4, ow);
            lk[d] = x.keep;
            lz[d] = x.dz;
            chk($sformatf("oleft[%0d]", d), ol, ll[d]);
            chk($sformatf("oright[%0d]", d), orr, lr[d]);
            chk($sformatf("okeep[%0d]", d), longint'(k), longint'(lk[d]));
            chk($sformatf("odet_zero[%0d]", d), longint'(z), longint'(lz[d]));
        end else if (!ov) begin
            chk($sformatf("hold_oleft[%0d]", d), ol, ll[d]);
            chk($sformatf("hold_oright[%0d]", d), orr, lr[d]);
            chk($sformatf("hold_okeep[%0d]", d), longint'(k), longint'(lk[d]));
            chk($sformatf("hold_odet_zero[%0d]", d), longint'(z), longint'(lz[d]));
        end
    endtask

    // Monitor: compares both instances against their scoreboards every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ifa.ovalid, longint'(ifa.oleft_value), longint'(ifa.oright_value),
                ifa.okeep, ifa.odet_zero);
            mon(1, ifb.ovalid, longint'(ifb.oleft_value), longint'(ifb.oright_value),
                ifb.okeep, ifb.odet_zero);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ovalid_a"}, longint'(ifa.ovalid), 0);
        chk({tag, "_okeep_a"}, longint'(ifa.okeep), 0);
        chk({tag, "_odet_zero_a"}, longint'(ifa.odet_zero), 0);
        chk({tag, "_oleft_a"}, longint'(ifa.oleft_value), 0);
        chk({tag, "_oright_a"}, longint'(ifa.oright_value), 0);
        chk({tag, "_ovalid_b"}, longint'(ifb.ovalid), 0);
        chk({tag, "_oleft_b"}, longint'(ifb.oleft_value), 0);
        chk({tag, "_oright_b"}, longint'(ifb.oright_value), 0);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            qs[d].delete();
            ll[d] = 0;
            lr[d] = 0;
            lk[d] = 1'b0;
            lz[d] = 1'b0;
        end
    endtask

    initial begin
        clear_model();
        ifa.ivalid = 1'b0;
        send(1'b0, 0, 0, id, gx, 0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Directed: keep case, threshold boundary, negative p, degenerate, saturation.
        send(1'b1, 10, 2, id, gx, 9);
        send(1'b1, 10, 2, id, gx, 10);
        send(1'b1, -10, 2, id, gx, 9);
        send(1'b1, 5, 0, id, gx, 3);
        send(1'b1, 255, 65535, id, gx, 100);
        send(1'b1, -256, -65536, id, gx, 255);
        repeat (4) send_rand(1'b0);

        // Streaming pattern 1,1,1,0,1 with distinct samples.
        send_rand(1'b1); send_rand(1'b1); send_rand(1'b1);
        send_rand(1'b0); send_rand(1'b1);
        repeat (10) send_rand(1'b0);

        // Reset with three samples in flight: outputs clear at once, samples vanish.
        send_rand(1'b1); send_rand(1'b1); send_rand(1'b1);
        send_rand(1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        clear_model();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) send_rand(1'b0);

        // First sample after release, then a randomised stream.
        send(1'b1, 10, 2, id, gx, 9);
        for (int n = 0; n < 400; n++) send_rand($urandom_range(0, 3) != 0);
        repeat (12) send_rand(1'b0);

        chk("drain_a", longint'(qs[0].size()), 0);
        chk("drain_b", longint'(qs[1].size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
